// File: rtl/mips_mem_pkg.sv
`default_nettype none
// mips_mem_pkg: access-size encodings, store exception codes and buffer entry type
// shared by the store narrowing path and the load-side extension unit.  rev 1.0
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] EXC_NONE          = 2'b00;
    localparam logic [1:0] EXC_ADES_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ADES_SIZE     = 2'b10;

    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } store_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_lane_format.sv
`default_nettype none
// store_lane_format: turns a byte-addressed store into a word-aligned write with
// replicated lanes and byte enables, flagging misaligned / reserved-size requests.  rev 1.0
module store_lane_format
    import mips_mem_pkg::*;
(
    input  logic [31:0]  addr,
    input  logic [1:0]   size,
    input  logic [31:0]  data,
    output store_entry_t entry,
    output logic         fault,
    output logic [1:0]   code
);

    always_comb begin
        entry.addr  = {addr[31:2], 2'b00};
        entry.wdata = data;
        entry.be    = '0;
        fault       = 1'b0;
        code        = EXC_NONE;
        case (size)
            SZ_BYTE: begin
                entry.wdata = {4{data[7:0]}};
                entry.be    = 4'b0001 << addr[1:0];
            end
            SZ_HALF: begin
                entry.wdata = {2{data[15:0]}};
                entry.be    = addr[1] ? 4'b1100 : 4'b0011;
                if (addr[0]) begin
                    fault = 1'b1;
                    code  = EXC_ADES_MISALIGN;
                end
            end
            SZ_WORD: begin
                entry.be = BE_WORD;
                if (addr[1:0] != 2'b00) begin
                    fault = 1'b1;
                    code  = EXC_ADES_MISALIGN;
                end
            end
            default: begin
                // Reserved size wins over any alignment problem.
                fault = 1'b1;
                code  = EXC_ADES_SIZE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_narrow_unit.sv
`default_nettype none
// store_narrow_unit: MEM-stage store formatter with a 2-entry write buffer and
// registered address-exception reporting.  rev 1.0
module store_narrow_unit
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_data,
    input  logic        flush,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        exc_valid,
    output logic [31:0] exc_addr,
    output logic [1:0]  exc_code
);

    localparam logic [1:0] CNT_FULL = 2'(DEPTH);

    store_entry_t fmt_entry;
    logic         fmt_fault;
    logic [1:0]   fmt_code;

    store_lane_format u_fmt (
        .addr  (req_addr),
        .size  (req_size),
        .data  (req_data),
        .entry (fmt_entry),
        .fault (fmt_fault),
        .code  (fmt_code)
    );

    store_entry_t stq_q [DEPTH];
    store_entry_t stq_d [DEPTH];
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         ready_q;
    logic         accept;
    logic         drain;
    logic         push;

    // ready_q depends only on the registered count, never on mem_ready.
    assign req_ready = ready_q && !flush;
    assign accept    = req_valid && req_ready;
    assign drain     = mem_valid && mem_ready;
    assign push      = accept && !fmt_fault;

    assign mem_valid = (count_q != 2'd0);
    assign mem_addr  = stq_q[0].addr;
    assign mem_wdata = stq_q[0].wdata;
    assign mem_be    = stq_q[0].be;

    always_comb begin
        stq_d   = stq_q;
        count_d = count_q;
        if (flush) begin
            // Only the head survives; if it drains now the buffer empties.
            if (drain) begin
                count_d = 2'd0;
            end else if (count_q != 2'd0) begin
                count_d = 2'd1;
            end
        end else begin
            if (drain) begin
                stq_d[0] = stq_q[1];
                count_d  = count_q - 2'd1;
            end
            if (push) begin
                stq_d[count_d[0]] = fmt_entry;
                count_d           = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            ready_q   <= 1'b0;
            exc_valid <= 1'b0;
            exc_addr  <= '0;
            exc_code  <= EXC_NONE;
            for (int i = 0; i < DEPTH; i++) begin
                stq_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            ready_q   <= (count_d < CNT_FULL);
            stq_q     <= stq_d;
            exc_valid <= accept && fmt_fault;
            if (accept && fmt_fault) begin
                exc_addr <= req_addr;
                exc_code <= fmt_code;
            end
        end
    end

endmodule
`default_nettype wire
